// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end: shifts 10-bit MOSI frames out as rx_data/rx_valid words and
// serialises the RAM read byte back onto MISO, all clocked by the SPI serial clock.
module spi_slave_ctrl #(
    parameter int TX_WAIT_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SS_n,
    input  logic       MOSI,
    output logic       MISO,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_ADD,
        READ_DATA,
        WAIT_TX,
        SEND,
        DONE
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(TX_WAIT_MAX - 1);

    state_t     state;
    logic [8:0] shift_reg;
    logic [3:0] bit_cnt;
    logic       rd_addr_flag;
    logic [7:0] tx_shift;
    logic [3:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            MISO         <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            rd_addr_flag <= 1'b0;
            tx_shift     <= '0;
            wait_cnt     <= '0;
        end else begin
            rx_valid <= 1'b0;
            // SS_n high aborts any frame in flight, even on its final bit.
            if (state != IDLE && SS_n) begin
                state   <= IDLE;
                MISO    <= 1'b0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!SS_n) begin
                            shift_reg <= {8'b0, MOSI};
                            bit_cnt   <= 4'd1;
                            if (!MOSI)
                                state <= WRITE;
                            else if (rd_addr_flag)
                                state <= READ_DATA;
                            else
                                state <= READ_ADD;
                        end
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (bit_cnt == 4'd9) begin
                            rx_data  <= {shift_reg, MOSI};
                            rx_valid <= 1'b1;
                            bit_cnt  <= '0;
                            if (state == WRITE) begin
                                state <= DONE;
                            end else if (state == READ_ADD) begin
                                rd_addr_flag <= 1'b1;
                                state        <= DONE;
                            end else begin
                                rd_addr_flag <= 1'b0;
                                wait_cnt     <= '0;
                                state        <= WAIT_TX;
                            end
                        end else begin
                            shift_reg <= {shift_reg[7:0], MOSI};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end
                    end
                    WAIT_TX: begin
                        if (tx_valid) begin
                            tx_shift <= tx_data;
                            MISO     <= tx_data[7];
                            bit_cnt  <= '0;
                            state    <= SEND;
                        end else if (wait_cnt == WAIT_LAST) begin
                            MISO  <= 1'b0;
                            state <= DONE;
                        end else begin
                            wait_cnt <= wait_cnt + 4'd1;
                        end
                    end
                    SEND: begin
                        // bit7 already went out on the load edge; seven more follow.
                        if (bit_cnt == 4'd7) begin
                            MISO    <= 1'b0;
                            bit_cnt <= '0;
                            state   <= DONE;
                        end else begin
                            MISO     <= tx_shift[6];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            bit_cnt  <= bit_cnt + 4'd1;
                        end
                    end
                    DONE: begin
                        MISO <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: write/read frames, read-data return on MISO,
// tx_valid timeout, SS_n aborts and asynchronous reset in the middle of SEND.
module tb_spi_slave_ctrl;

    logic       clk;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int tests  = 0;
    int failed = 0;

    spi_slave_ctrl #(.TX_WAIT_MAX(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive inputs on the falling edge, return 1 time unit after the next rising edge.
    task automatic cyc(input logic ss, input logic mosi, input logic tv, input logic [7:0] td);
        @(negedge clk);
        SS_n     = ss;
        MOSI     = mosi;
        tx_valid = tv;
        tx_data  = td;
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input string tag, input logic [9:0] w);
        for (int i = 9; i >= 0; i--) begin
            cyc(1'b0, w[i], 1'b0, 8'h00);
            if (i > 0) chk({tag, "_rxv_mid"}, 16'(rx_valid), 16'h0);
        end
        chk({tag, "_rxv_e9"}, 16'(rx_valid), 16'h1);
        chk({tag, "_rx_data"}, 16'(rx_data), 16'(w));
        chk({tag, "_miso"}, 16'(MISO), 16'h0);
    endtask

    task automatic end_frame(input string tag, input logic [9:0] held);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk({tag, "_rxv_end"}, 16'(rx_valid), 16'h0);
        chk({tag, "_rx_hold"}, 16'(rx_data), 16'(held));
    endtask

    initial begin
        logic [7:0] rd_byte;
        logic [9:0] w;

        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_miso", 16'(MISO), 16'h0);
        chk("rst_rxv", 16'(rx_valid), 16'h0);
        chk("rst_rx_data", 16'(rx_data), 16'h0);
        rst_n = 1'b1;

        // 1: first write-address frame
        frame("t1", 10'h032);
        end_frame("t1", 10'h032);

        // 2: write-data frame
        frame("t2", 10'h1A5);
        end_frame("t2", 10'h1A5);

        // 3: read address, then read data returning 0xA5 on MISO
        frame("t3a", 10'h232);
        end_frame("t3a", 10'h232);
        frame("t3d", 10'h3C7);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("t3_e10_rxv", 16'(rx_valid), 16'h0);
        chk("t3_e10_miso", 16'(MISO), 16'h0);
        rd_byte = 8'hA5;
        for (int b = 7; b >= 0; b--) begin
            cyc(1'b0, 1'b0, (b == 7), (b == 7) ? rd_byte : 8'h00);
            chk($sformatf("t3_miso_b%0d", b), 16'(MISO), 16'(rd_byte[b]));
        end
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("t3_e19_miso", 16'(MISO), 16'h0);
        cyc(1'b0, 1'b1, 1'b1, 8'hFF);
        chk("t3_done_miso", 16'(MISO), 16'h0);
        chk("t3_done_rxv", 16'(rx_valid), 16'h0);
        end_frame("t3d", 10'h3C7);

        // 4: read data with no tx_valid; DONE after 4 waiting edges
        frame("t4a", 10'h2AA);
        end_frame("t4a", 10'h2AA);
        frame("t4d", 10'h355);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 8'h00);
            chk($sformatf("t4_wait%0d_miso", k), 16'(MISO), 16'h0);
        end
        cyc(1'b0, 1'b0, 1'b1, 8'hFF);
        chk("t4_late_tx_ignored", 16'(MISO), 16'h0);
        end_frame("t4d", 10'h355);
        frame("t4n", 10'h3FF);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'h80);
        chk("t4_flag_clear_miso", 16'(MISO), 16'h0);
        end_frame("t4n", 10'h3FF);
        frame("t4r", 10'h300);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'hC0);
        chk("t4r_miso_b7", 16'(MISO), 16'h1);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("t4r_miso_b6", 16'(MISO), 16'h1);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("t4r_abort_miso", 16'(MISO), 16'h0);

        // 5: abort after 6 bits, full frame, then abort on the E9 edge
        w = 10'h0F0;
        for (int i = 9; i >= 4; i--) cyc(1'b0, w[i], 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("t5_abort_rxv", 16'(rx_valid), 16'h0);
        chk("t5_abort_hold", 16'(rx_data), 16'h300);
        frame("t5", 10'h0FF);
        end_frame("t5", 10'h0FF);
        w = 10'h155;
        for (int i = 9; i >= 1; i--) cyc(1'b0, w[i], 1'b0, 8'h00);
        cyc(1'b1, w[0], 1'b0, 8'h00);
        chk("t5_e9abort_rxv", 16'(rx_valid), 16'h0);
        chk("t5_e9abort_hold", 16'(rx_data), 16'h0FF);
        frame("t5b", 10'h155);
        end_frame("t5b", 10'h155);

        // 6: asynchronous reset while SEND is driving bit 3
        frame("t6a", 10'h200);
        end_frame("t6a", 10'h200);
        frame("t6d", 10'h3AB);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'hFF);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("t6_miso_b3", 16'(MISO), 16'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_miso", 16'(MISO), 16'h0);
        chk("t6_rst_rxv", 16'(rx_valid), 16'h0);
        chk("t6_rst_rx_data", 16'(rx_data), 16'h0);
        SS_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        frame("t6n", 10'h3FF);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'hFF);
        chk("t6_flag_reset_miso", 16'(MISO), 16'h0);
        end_frame("t6n", 10'h3FF);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
SPI slave front-end that deserialises MOSI frames into the 10-bit command/data words consumed by the single-port RAM (rx_data/rx_valid). It also serialises the RAM's read data (tx_data/tx_valid) back onto MISO. It sits between the external SPI master and the RAM, and clk is the SPI serial clock.

Parameters:
TX_WAIT_MAX, 4, max clk cycles to wait for tx_valid after a read-data rx_valid before abandoning the read (range 1..15)

Ports:
clk  in  1  SPI serial clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
SS_n  in  1  slave select, active low; high = bus idle / frame abort
MOSI  in  1  serial data in, MSB first, sampled on rising clk
MISO  out  1  serial data out, MSB first, registered, changes after rising clk
rx_data  out  10  word to RAM: [9:8] command, [7:0] address/data
rx_valid  out  1  one-cycle pulse, rx_data valid
tx_data  in  8  read data from RAM
tx_valid  in  1  tx_data valid (RAM drives it 1 cycle after seeing rx_valid with rx_data[9:8]=11)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; MISO=0; rx_data=0; rx_valid=0; bit counter=0; rd_addr_flag=0; tx shift reg=0; wait counter=0.
- States: IDLE, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, DONE.
- Edge numbering: E0 = first rising edge with SS_n=0 while in IDLE. E0 samples bit9 into the shift register.
  - bit9=0 -> WRITE.
  - bit9=1 and rd_addr_flag=0 -> READ_ADD.
  - bit9=1 and rd_addr_flag=1 -> READ_DATA.
- WRITE/READ_ADD/READ_DATA: edges E1..E9 shift bits 8..0 in. At E9, rx_data <= full 10-bit word and rx_valid <= 1 for exactly one cycle (deasserted at E10).
- rx_data holds its value until the next completed frame.
- The slave forwards [9:8] unmodified; command decode is the RAM's job.
- Frame completion, WRITE -> DONE.
- Frame completion, READ_ADD -> rd_addr_flag <= 1, then DONE.
- Frame completion, READ_DATA -> rd_addr_flag <= 0, wait counter cleared, then WAIT_TX.
- WAIT_TX:
  - On a rising edge with tx_valid=1: load tx_data into the tx shift reg, MISO <= tx_data[7], go to SEND. Nominal: tx_valid seen at E11, MISO=bit7 after E11.
  - Otherwise increment the wait counter. After TX_WAIT_MAX edges without tx_valid -> DONE with MISO=0.
- SEND: MISO <= bits 6..0 on the next 7 edges (E12..E18). On the edge after bit0 (E19), MISO <= 0 and go to DONE.
- DONE: MISO=0; ignore MOSI; go to IDLE on the first edge with SS_n=1.
- SS_n=1 sampled in any non-IDLE state: next state IDLE, MISO <= 0, bit counter cleared.
  - No rx_valid for the partial frame; rd_addr_flag unchanged.
  - If the abort occurs in the same edge as E9, the frame is discarded (SS_n takes priority).
- tx_valid outside WAIT_TX is ignored.
- rx_valid is never asserted in IDLE, DONE, WAIT_TX or SEND.
- Back-to-back frames: master must raise SS_n for at least one edge between frames; SS_n held low after DONE produces no new frame.
- Reset mid-frame: immediate return to reset values, including rd_addr_flag=0.

Test Plan:
1. After reset, SS_n=0, MOSI=10'b00_0011_0010 MSB first -> rx_valid one pulse after E9 with rx_data=0x032; MISO=0 throughout; SS_n=1 -> IDLE.
2. Write data frame 10'b01_1010_0101 -> rx_data=0x1A5, single rx_valid pulse; rd_addr_flag stays 0.
3. Read address frame 10'b10_0011_0010 -> rx_data=0x232, flag set. Then read data frame 10'b11_xxxx_xxxx -> rx_data[9:8]=11, flag cleared. RAM model returns tx_data=0xA5 with tx_valid 1 cycle after rx_valid -> MISO shows 1,0,1,0,0,1,0,1 on E11..E18, then 0.
4. Read data frame with tx_valid never asserted, TX_WAIT_MAX=4 -> MISO stays 0, state DONE after 4 waiting edges; next frame with bit9=1 goes to READ_ADD (flag was cleared).
5. Abort: SS_n=1 after 6 bits of a write frame -> no rx_valid, IDLE next edge; subsequent full frame 0x0FF decoded correctly.
6. rst_n=0 asynchronously during SEND at bit 3 -> MISO=0, rx_valid=0 immediately (before next clk edge); flag=0, so next bit9=1 frame enters READ_ADD.
